hazard_scoreboard: RTL and testbench

//  Parametrised decode-stage hazard unit for the 5-stage MIPS pipeline. It replaces per-stage rd

---
 rtl/hazard_scoreboard.sv | 128 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: a per-register countdown scoreboard replaces the usual
// rd comparators and drives the PC / IF-ID / control-bubble enables.
module hazard_scoreboard #(
    parameter int NREGS    = 32,
    parameter int REG_W    = 5,
    parameter int ALU_LAT  = 2,
    parameter int LOAD_LAT = 3,
    parameter int FWD_EN   = 1,
    parameter int ALU_THR  = 2,
    parameter int BR_THR   = 1,
    parameter int SCNT_W   = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IssueValid,
    input  logic [REG_W-1:0]  Rs,
    input  logic [REG_W-1:0]  Rt,
    input  logic              UsesRs,
    input  logic              UsesRt,
    input  logic [REG_W-1:0]  Rd,
    input  logic              RegWrite,
    input  logic              IsLoad,
    input  logic              Branch,
    input  logic              BranchOutput,
    input  logic              IsJr,
    output logic              PCWrite,
    output logic              DecodeRegWrite,
    output logic              MuxControl,
    output logic              flushControl,
    output logic [SCNT_W-1:0] StallCount
);

    localparam int CNT_W = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

    // Without forwarding every consumer has to wait for the producer to fully drain.
    localparam logic [31:0] ALU_T = (FWD_EN != 0) ? 32'(ALU_THR) : 32'd0;
    localparam logic [31:0] BR_T  = (FWD_EN != 0) ? 32'(BR_THR)  : 32'd0;

    localparam logic [CNT_W-1:0] ALU_LOAD  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LOAD_LOAD = CNT_W'(LOAD_LAT);

    // cntQ[i] tracks architectural register i+1; register 0 is never busy.
    logic [CNT_W-1:0] cntQ    [NREGS-1];
    logic [CNT_W-1:0] nextCnt [NREGS-1];

    logic [CNT_W-1:0] rsCnt;
    logic [CNT_W-1:0] rtCnt;
    logic [CNT_W-1:0] newLoad;
    logic [31:0]      thr;
    logic             readsRs;
    logic             rsHazard;
    logic             rtHazard;
    logic             stall;
    logic             issue;
    logic             writeRd;

    function automatic logic [CNT_W-1:0] satDec(input logic [CNT_W-1:0] x);
        return (x == '0) ? '0 : x - CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] maxCnt(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        rsCnt = '0;
        rtCnt = '0;
        for (int r = 1; r < NREGS; r++) begin
            if (Rs == REG_W'(r)) rsCnt = cntQ[r-1];
            if (Rt == REG_W'(r)) rtCnt = cntQ[r-1];
        end
    end

    // jr always reads Rs, whatever the decoder says about UsesRs.
    assign readsRs  = UsesRs | IsJr;
    assign thr      = (Branch | IsJr) ? BR_T : ALU_T;
    assign rsHazard = readsRs & (32'(rsCnt) > thr);
    assign rtHazard = UsesRt & (32'(rtCnt) > thr);
    assign stall    = IssueValid & (rsHazard | rtHazard);
    assign issue    = IssueValid & ~stall;
    assign writeRd  = issue & RegWrite & (Rd != '0);
    assign newLoad  = IsLoad ? LOAD_LOAD : ALU_LOAD;

    // A fresh producer never shortens an older, longer countdown on the same register.
    always_comb begin
        for (int r = 0; r < NREGS - 1; r++) begin
            nextCnt[r] = satDec(cntQ[r]);
            if (writeRd && (Rd == REG_W'(r + 1))) begin
                nextCnt[r] = maxCnt(newLoad, satDec(cntQ[r]));
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int r = 0; r < NREGS - 1; r++) begin
                cntQ[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS - 1; r++) begin
                cntQ[r] <= nextCnt[r];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            StallCount <= '0;
        end else if (stall && (StallCount != '1)) begin
            StallCount <= StallCount + SCNT_W'(1);
        end
    end

    always_comb begin
        PCWrite        = 1'b0;
        DecodeRegWrite = 1'b0;
        MuxControl     = 1'b0;
        flushControl   = 1'b0;
        if (Reset && !stall) begin
            PCWrite        = 1'b1;
            DecodeRegWrite = 1'b1;
            MuxControl     = 1'b1;
            flushControl   = IssueValid & ((Branch & BranchOutput) | IsJr);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, hand-written reset/forwarding/saturation
// sequences, and random traffic against a ready-time reference model.
module tb_hazard_scoreboard;

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRs;
        logic       usesRt;
        logic [4:0] rd;
        logic       regWrite;
        logic       isLoad;
        logic       branch;
        logic       brOut;
        logic       isJr;
        logic [3:0] expCtl;
        int         expCount;
    } VectorT;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       IssueValid, UsesRs, UsesRt, RegWrite, IsLoad, Branch, BranchOutput, IsJr;
    logic [4:0] Rs, Rt, Rd;

    logic        fwPC, fwDec, fwMux, fwFlush;
    logic [15:0] fwCount;
    logic        nfPC, nfDec, nfMux, nfFlush;
    logic [15:0] nfCount;
    logic        saPC, saDec, saMux, saFlush;
    logic [7:0]  saCount;

    int tests = 0;
    int failures = 0;

    int readyAt [2][32];
    int modelCount [2];
    logic modelStallQ [2];
    int now;

    VectorT vecs [25];

    always #5 Clk = ~Clk;

    hazard_scoreboard dut (
        .Clk(Clk), .Reset(Reset), .IssueValid(IssueValid), .Rs(Rs), .Rt(Rt),
        .UsesRs(UsesRs), .UsesRt(UsesRt), .Rd(Rd), .RegWrite(RegWrite), .IsLoad(IsLoad),
        .Branch(Branch), .BranchOutput(BranchOutput), .IsJr(IsJr),
        .PCWrite(fwPC), .DecodeRegWrite(fwDec), .MuxControl(fwMux),
        .flushControl(fwFlush), .StallCount(fwCount)
    );

    hazard_scoreboard #(.FWD_EN(0)) dutNoFwd (
        .Clk(Clk), .Reset(Reset), .IssueValid(IssueValid), .Rs(Rs), .Rt(Rt),
        .UsesRs(UsesRs), .UsesRt(UsesRt), .Rd(Rd), .RegWrite(RegWrite), .IsLoad(IsLoad),
        .Branch(Branch), .BranchOutput(BranchOutput), .IsJr(IsJr),
        .PCWrite(nfPC), .DecodeRegWrite(nfDec), .MuxControl(nfMux),
        .flushControl(nfFlush), .StallCount(nfCount)
    );

    hazard_scoreboard #(.LOAD_LAT(15), .FWD_EN(0), .SCNT_W(8)) dutSat (
        .Clk(Clk), .Reset(Reset), .IssueValid(IssueValid), .Rs(Rs), .Rt(Rt),
        .UsesRs(UsesRs), .UsesRt(UsesRt), .Rd(Rd), .RegWrite(RegWrite), .IsLoad(IsLoad),
        .Branch(Branch), .BranchOutput(BranchOutput), .IsJr(IsJr),
        .PCWrite(saPC), .DecodeRegWrite(saDec), .MuxControl(saMux),
        .flushControl(saFlush), .StallCount(saCount)
    );

    function automatic VectorT mkVec(input logic v, input int rs, input int rt,
                                     input logic ur, input logic ut, input int rd,
                                     input logic rw, input logic ld, input logic br,
                                     input logic bo, input logic jr,
                                     input logic [3:0] ctl, input int cnt);
        VectorT t;
        t.valid = v;   t.rs = 5'(rs);  t.rt = 5'(rt);   t.usesRs = ur; t.usesRt = ut;
        t.rd = 5'(rd); t.regWrite = rw; t.isLoad = ld; t.branch = br;  t.brOut = bo;
        t.isJr = jr;   t.expCtl = ctl; t.expCount = cnt;
        return t;
    endfunction

    task automatic applyStimulus(input VectorT v);
        IssueValid = v.valid;  Rs = v.rs;  Rt = v.rt;  UsesRs = v.usesRs;  UsesRt = v.usesRt;
        Rd = v.rd;  RegWrite = v.regWrite;  IsLoad = v.isLoad;  Branch = v.branch;
        BranchOutput = v.brOut;  IsJr = v.isJr;
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expCtl, input int expCount);
        checkValue({tag, " ctl"}, int'({fwPC, fwDec, fwMux, fwFlush}), int'(expCtl));
        checkValue({tag, " count"}, int'(fwCount), expCount);
    endtask

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic resetCycle();
        Reset = 1'b0;
        IssueValid = 1'b0;
        nextCycle();
        Reset = 1'b1;
    endtask

    // Reference model: each register holds the cycle at which its value is forwardable.
    function automatic int remaining(input int k, input int r);
        if (r == 0) return 0;
        return (readyAt[k][r] > now) ? readyAt[k][r] - now : 0;
    endfunction

    function automatic logic modelStall(input int k);
        int thr;
        thr = (k == 0) ? ((Branch || IsJr) ? 1 : 2) : 0;
        return IssueValid && (((UsesRs || IsJr) && remaining(k, int'(Rs)) > thr) ||
                              (UsesRt && remaining(k, int'(Rt)) > thr));
    endfunction

    function automatic logic [3:0] modelCtl(input logic st);
        if (!Reset || st) return 4'b0000;
        return {3'b111, IssueValid && ((Branch && BranchOutput) || IsJr)};
    endfunction

    task automatic modelEdge();
        for (int k = 0; k < 2; k++) begin
            if (!Reset) begin
                for (int r = 0; r < 32; r++) readyAt[k][r] = 0;
                modelCount[k] = 0;
            end else begin
                if (!modelStallQ[k] && IssueValid && RegWrite && Rd != 5'd0) begin
                    int lat;
                    lat = IsLoad ? 3 : 2;
                    if (now + 1 + lat > readyAt[k][Rd]) readyAt[k][Rd] = now + 1 + lat;
                end
                if (modelStallQ[k] && modelCount[k] < 65535) modelCount[k]++;
            end
        end
        now++;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // v  rs rt uRs uRt rd rw ld br bo jr  ctl     count
        vecs[0]  = mkVec(1, 29, 0, 1, 0, 8, 1, 1, 0, 0, 0, 4'b1110, 0);
        vecs[1]  = mkVec(1, 8, 10, 1, 1, 9, 1, 0, 0, 0, 0, 4'b0000, 0);
        vecs[2]  = mkVec(1, 8, 10, 1, 1, 9, 1, 0, 0, 0, 0, 4'b1110, 1);
        vecs[3]  = mkVec(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0, 4'b1110, 1);
        vecs[4]  = mkVec(1, 8, 0, 1, 1, 0, 0, 0, 1, 1, 0, 4'b0000, 1);
        vecs[5]  = mkVec(1, 8, 0, 1, 1, 0, 0, 0, 1, 1, 0, 4'b1111, 2);
        vecs[6]  = mkVec(1, 29, 0, 1, 0, 8, 1, 1, 0, 0, 0, 4'b1110, 2);
        vecs[7]  = mkVec(1, 8, 0, 1, 1, 0, 0, 0, 1, 0, 0, 4'b0000, 2);
        vecs[8]  = mkVec(1, 8, 0, 1, 1, 0, 0, 0, 1, 0, 0, 4'b0000, 3);
        vecs[9]  = mkVec(1, 8, 0, 1, 1, 0, 0, 0, 1, 0, 0, 4'b1110, 4);
        vecs[10] = mkVec(1, 1, 2, 1, 1, 31, 1, 0, 0, 0, 0, 4'b1110, 4);
        vecs[11] = mkVec(1, 31, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4);
        vecs[12] = mkVec(1, 31, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 5);
        vecs[13] = mkVec(1, 29, 0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b1110, 5);
        vecs[14] = mkVec(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 0, 4'b1110, 5);
        vecs[15] = mkVec(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 4'b1110, 5);
        vecs[16] = mkVec(1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 4'b1111, 5);
        vecs[17] = mkVec(1, 29, 0, 1, 0, 8, 1, 1, 0, 0, 0, 4'b1110, 5);
        vecs[18] = mkVec(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0, 4'b1110, 5);
        vecs[19] = mkVec(1, 8, 3, 1, 1, 0, 0, 0, 1, 0, 0, 4'b0000, 5);
        vecs[20] = mkVec(1, 8, 3, 1, 1, 0, 0, 0, 1, 0, 0, 4'b1110, 6);
        vecs[21] = mkVec(1, 8, 3, 1, 1, 9, 1, 0, 0, 0, 0, 4'b1110, 6);
        vecs[22] = mkVec(1, 29, 0, 1, 0, 8, 1, 1, 0, 0, 0, 4'b1110, 6);
        vecs[23] = mkVec(0, 8, 0, 1, 0, 10, 1, 1, 1, 1, 0, 4'b1110, 6);
        vecs[24] = mkVec(1, 8, 10, 1, 1, 9, 1, 0, 0, 0, 0, 4'b1110, 6);

        // Held in reset with a taken branch presented: every enable must stay low.
        Reset = 1'b0;
        applyStimulus(vecs[16]);
        @(posedge Clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            checkOutput($sformatf("reset%0d", i), 4'b0000, 0);
            nextCycle();
        end
        Reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i]);
            @(negedge Clk);
            checkOutput($sformatf("vec%0d", i), vecs[i].expCtl, vecs[i].expCount);
            nextCycle();
        end

        // ALU->ALU: no stall with forwarding, two stalls without.
        begin
            int stalls;
            resetCycle();
            applyStimulus(mkVec(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0, 4'b0, 0));
            nextCycle();
            applyStimulus(mkVec(1, 8, 0, 1, 1, 9, 1, 0, 0, 0, 0, 4'b0, 0));
            @(negedge Clk);
            checkValue("alu-alu fwd PCWrite", int'(fwPC), 1);
            stalls = 0;
            for (int i = 0; i < 10; i++) begin
                if (i > 0) @(negedge Clk);
                if (nfPC) break;
                stalls++;
                nextCycle();
            end
            checkValue("alu-alu nofwd stalls", stalls, 2);
            checkValue("alu-alu nofwd count", int'(nfCount), 2);
            nextCycle();
        end

        // Reset in the middle of a load->branch stall.
        resetCycle();
        applyStimulus(mkVec(1, 29, 0, 1, 0, 8, 1, 1, 0, 0, 0, 4'b0, 0));
        nextCycle();
        applyStimulus(mkVec(1, 8, 0, 1, 1, 0, 0, 0, 1, 1, 0, 4'b0, 0));
        @(negedge Clk);
        checkOutput("midstall pre", 4'b0000, 0);
        nextCycle();
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("midstall in reset", 4'b0000, 1);
        checkValue("midstall nofwd ctl", int'({nfPC, nfDec, nfMux, nfFlush}), 0);
        nextCycle();
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("midstall release", 4'b1111, 0);
        checkValue("midstall nofwd release ctl", int'({nfPC, nfDec, nfMux, nfFlush}), 15);
        checkValue("midstall nofwd count", int'(nfCount), 0);
        nextCycle();

        // Saturation: a self-dependent long load stalls 15 of every 16 cycles.
        resetCycle();
        applyStimulus(mkVec(1, 8, 0, 1, 0, 8, 1, 1, 0, 0, 0, 4'b0, 0));
        for (int i = 0; i < 16; i++) nextCycle();
        @(negedge Clk);
        checkValue("sat early count", int'(saCount), 15);
        for (int i = 0; i < 300; i++) nextCycle();
        @(negedge Clk);
        checkValue("sat final count", int'(saCount), 255);
        nextCycle();

        // Random traffic on both the forwarding and non-forwarding builds.
        resetCycle();
        now = 0;
        for (int k = 0; k < 2; k++) begin
            modelCount[k] = 0;
            for (int r = 0; r < 32; r++) readyAt[k][r] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            VectorT v;
            v = mkVec($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 7),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                      $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35,
                      $urandom_range(0, 99) < 20, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 99) < 8, 4'b0, 0);
            Reset = ($urandom_range(0, 99) != 0);
            applyStimulus(v);
            @(negedge Clk);
            modelStallQ[0] = modelStall(0);
            modelStallQ[1] = modelStall(1);
            checkValue($sformatf("rand%0d fwd ctl", c), int'({fwPC, fwDec, fwMux, fwFlush}),
                       int'(modelCtl(modelStallQ[0])));
            checkValue($sformatf("rand%0d fwd count", c), int'(fwCount), modelCount[0]);
            checkValue($sformatf("rand%0d nofwd ctl", c), int'({nfPC, nfDec, nfMux, nfFlush}),
                       int'(modelCtl(modelStallQ[1])));
            checkValue($sformatf("rand%0d nofwd count", c), int'(nfCount), modelCount[1]);
            @(posedge Clk);
            modelEdge();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
